// File: rtl/control_block.sv
// control_block: test sequencer feeding one transaction descriptor at a time
// to the transmitter over a valid/ready handshake.
// Ports:
//   clk_i, rst_n_i                      clock, async active-low reset
//   start_test_i, test_mode_i,          start pulse and test configuration,
//   addr_mode_i, fix_addr_i,            sampled on an accepted start
//   trans_amount_i, burstcount_i
//   trans_ready_i, trans_busy_i         transmitter handshake / activity
//   cmp_error_i                         compare-mismatch pulse
//   trans_valid_o, trans_addr_o,        descriptor to the transmitter
//   trans_type_o                        (type 0 write, 1 read)
//   test_busy_o, test_done_o,           status to CSR
//   test_error_o, trans_cnt_o
module control_block #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned AMM_BURST_W = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_test_i,
  input  logic [1:0]             test_mode_i,
  input  logic [1:0]             addr_mode_i,
  input  logic [ADDR_W-1:0]      fix_addr_i,
  input  logic [31:0]            trans_amount_i,
  input  logic [AMM_BURST_W-2:0] burstcount_i,
  input  logic                   trans_ready_i,
  input  logic                   trans_busy_i,
  input  logic                   cmp_error_i,
  output logic                   trans_valid_o,
  output logic [ADDR_W-1:0]      trans_addr_o,
  output logic                   trans_type_o,
  output logic                   test_busy_o,
  output logic                   test_done_o,
  output logic                   test_error_o,
  output logic [31:0]            trans_cnt_o
);

  localparam logic [1:0]  MODE_RD   = 2'd0;
  localparam logic [1:0]  MODE_WC   = 2'd2;
  localparam logic [1:0]  MODE_RSV  = 2'd3;
  localparam logic [1:0]  ADDR_RUN  = 2'd1;
  localparam logic [1:0]  ADDR_RND  = 2'd2;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
  // Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [1:0]             amode_q, amode_d;
  logic [ADDR_W-1:0]      fix_q, fix_d;
  logic [AMM_BURST_W-2:0] burst_q, burst_d;
  logic [31:0]            amount_q, amount_d;
  logic [31:0]            lfsr_q, lfsr_d;

  logic                   valid_d, type_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [31:0]            cnt_d;

  logic [31:0]            lfsr_adv;
  logic [ADDR_W-1:0]      addr_adv;
  logic                   accept;
  logic                   last_phase;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  assign lfsr_adv   = lfsr_next(lfsr_q);
  assign accept     = trans_valid_o & trans_ready_i;
  // a transaction completes on its only descriptor, or on the read of a pair
  assign last_phase = (mode_q != MODE_WC) || trans_type_o;

  // address generator: value after one advance
  always_comb begin
    addr_adv = fix_q;
    case (amode_q)
      ADDR_RUN: addr_adv = trans_addr_o + ADDR_W'(burst_q) + ADDR_W'(1);
      ADDR_RND: addr_adv = lfsr_adv[ADDR_W-1:0];
      default:  addr_adv = fix_q;
    endcase
  end

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    amode_d  = amode_q;
    fix_d    = fix_q;
    burst_d  = burst_q;
    amount_d = amount_q;
    lfsr_d   = lfsr_q;
    valid_d  = trans_valid_o;
    addr_d   = trans_addr_o;
    type_d   = trans_type_o;
    busy_d   = test_busy_o;
    done_d   = 1'b0;
    err_d    = test_error_o;
    cnt_d    = trans_cnt_o;

    case (state_q)
      IDLE: begin
        if (start_test_i && (test_mode_i != MODE_RSV)) begin
          mode_d   = test_mode_i;
          amode_d  = addr_mode_i;
          fix_d    = fix_addr_i;
          burst_d  = burstcount_i;
          amount_d = trans_amount_i;
          cnt_d    = 32'd0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          type_d   = (test_mode_i == MODE_RD);
          if (addr_mode_i == ADDR_RND) begin
            lfsr_d = lfsr_adv;
            addr_d = lfsr_adv[ADDR_W-1:0];
          end else begin
            addr_d = fix_addr_i;
          end
          if (trans_amount_i == 32'd0) begin
            state_d = DRAIN;
          end else begin
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          if (!last_phase) begin
            type_d = 1'b1;
          end else begin
            cnt_d  = trans_cnt_o + 32'd1;
            addr_d = addr_adv;
            type_d = (mode_q == MODE_RD);
            if (amode_q == ADDR_RND) lfsr_d = lfsr_adv;
            if (cnt_d == amount_q) begin
              valid_d = 1'b0;
              state_d = DRAIN;
            end
          end
        end
        // abort wins over a pending descriptor; a same-cycle accept still counts
        if (cmp_error_i) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cmp_error_i) err_d = 1'b1;
        if (!trans_busy_i) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (cmp_error_i) err_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      amode_q       <= 2'd0;
      fix_q         <= '0;
      burst_q       <= '0;
      amount_q      <= 32'd0;
      lfsr_q        <= LFSR_SEED;
      trans_valid_o <= 1'b0;
      trans_addr_o  <= '0;
      trans_type_o  <= 1'b0;
      test_busy_o   <= 1'b0;
      test_done_o   <= 1'b0;
      test_error_o  <= 1'b0;
      trans_cnt_o   <= 32'd0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      amode_q       <= amode_d;
      fix_q         <= fix_d;
      burst_q       <= burst_d;
      amount_q      <= amount_d;
      lfsr_q        <= lfsr_d;
      trans_valid_o <= valid_d;
      trans_addr_o  <= addr_d;
      trans_type_o  <= type_d;
      test_busy_o   <= busy_d;
      test_done_o   <= done_d;
      test_error_o  <= err_d;
      trans_cnt_o   <= cnt_d;
    end
  end

endmodule
